// File: rtl/i2c_reg_ctrl.sv
// Register-access sequencer for a byte-level I2C master: turns one register write or a
// 1-4 byte burst read into START/WRITE/READ/STOP steps and generates the shared SCL phase tick.
module i2c_reg_ctrl #(
    parameter int CLK_HZ        = 100_000_000,
    parameter int TICK_HZ       = 400_000,
    parameter int TIMEOUT_TICKS = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    input  logic [1:0] rd_len,
    output logic       ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       resp_valid,
    output logic       err,
    output logic       timeout,
    output logic       m_tick,
    output logic       m_start,
    output logic       m_stop,
    output logic       m_write,
    output logic       m_read,
    output logic       m_ack_in,
    output logic [7:0] m_data_in,
    input  logic [7:0] m_data_out,
    input  logic       m_done,
    input  logic       m_busy,
    input  logic       m_ack_err
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int OW       = $clog2(TIMEOUT_TICKS + 1);

    typedef enum logic [2:0] {
        IDLE, S_ADDR_W, S_REG, S_WDATA, S_ADDR_R, S_RD, S_STOP, RESP
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_gap, w_gap_nxt;
    logic [OW-1:0]   r_to_cnt, w_to_nxt;
    logic [TW-1:0]   r_tick_cnt;
    logic [1:0]      r_cnt, w_cnt_nxt;
    logic            r_rw;
    logic [6:0]      r_dev;
    logic [7:0]      r_reg;
    logic [7:0]      r_wdata;
    logic            r_rd_valid, w_rd_valid_nxt;
    logic [7:0]      r_rd_data, w_rd_data_nxt;
    logic            r_err, w_err_nxt;
    logic            r_timeout, w_timeout_nxt;
    logic            w_accept;
    logic            w_unused;

    // The busy flag is informational only; the handshake relies solely on m_done.
    assign w_unused = m_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == TW'(TICK_DIV - 1)) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    assign m_tick     = (r_tick_cnt == TW'(TICK_DIV - 1));
    assign ready      = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign rd_valid   = r_rd_valid;
    assign rd_data    = r_rd_data;
    assign err        = r_err;
    assign timeout    = r_timeout;
    assign w_accept   = (r_state == IDLE) && req;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_gap      <= 1'b0;
            r_to_cnt   <= '0;
            r_cnt      <= '0;
            r_rw       <= 1'b0;
            r_dev      <= '0;
            r_reg      <= '0;
            r_wdata    <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_err      <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gap      <= w_gap_nxt;
            r_to_cnt   <= w_to_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rd_valid <= w_rd_valid_nxt;
            r_rd_data  <= w_rd_data_nxt;
            r_err      <= w_err_nxt;
            r_timeout  <= w_timeout_nxt;
            if (w_accept) begin
                r_rw    <= rw;
                r_dev   <= dev_addr;
                r_reg   <= reg_addr;
                r_wdata <= wdata;
            end
        end
    end

    // r_gap blanks all commands after each m_done until a tick has passed.
    always_comb begin
        w_state_nxt    = r_state;
        w_gap_nxt      = r_gap;
        w_to_nxt       = r_to_cnt;
        w_cnt_nxt      = r_cnt;
        w_rd_valid_nxt = 1'b0;
        w_rd_data_nxt  = r_rd_data;
        w_err_nxt      = r_err;
        w_timeout_nxt  = r_timeout;
        m_start        = 1'b0;
        m_stop         = 1'b0;
        m_write        = 1'b0;
        m_read         = 1'b0;
        m_ack_in       = 1'b0;
        m_data_in      = 8'h00;
        case (r_state)
            IDLE: begin
                if (req) begin
                    w_state_nxt   = S_ADDR_W;
                    w_gap_nxt     = 1'b0;
                    w_to_nxt      = '0;
                    w_cnt_nxt     = rd_len;
                    w_err_nxt     = 1'b0;
                    w_timeout_nxt = 1'b0;
                end
            end
            RESP: w_state_nxt = IDLE;
            default: begin
                if (r_gap) begin
                    if (m_tick) w_gap_nxt = 1'b0;
                end else begin
                    case (r_state)
                        S_ADDR_W: begin
                            m_start   = 1'b1;
                            m_write   = 1'b1;
                            m_data_in = {r_dev, 1'b0};
                        end
                        S_REG: begin
                            m_write   = 1'b1;
                            m_data_in = r_reg;
                        end
                        S_WDATA: begin
                            m_write   = 1'b1;
                            m_data_in = r_wdata;
                        end
                        S_ADDR_R: begin
                            m_start   = 1'b1;
                            m_write   = 1'b1;
                            m_data_in = {r_dev, 1'b1};
                        end
                        S_RD: begin
                            m_read   = 1'b1;
                            m_ack_in = (r_cnt == 2'd0);
                        end
                        S_STOP:  m_stop = 1'b1;
                        default: ;
                    endcase
                    // m_done is checked before the timeout so a coincident completion wins.
                    if (m_done) begin
                        w_gap_nxt = 1'b1;
                        w_to_nxt  = '0;
                        if (m_ack_err && (r_state != S_RD) && (r_state != S_STOP)) begin
                            w_state_nxt   = RESP;
                            w_gap_nxt     = 1'b0;
                            w_err_nxt     = 1'b1;
                            w_timeout_nxt = 1'b0;
                        end else begin
                            case (r_state)
                                S_ADDR_W: w_state_nxt = S_REG;
                                S_REG:    w_state_nxt = r_rw ? S_ADDR_R : S_WDATA;
                                S_WDATA:  w_state_nxt = S_STOP;
                                S_ADDR_R: w_state_nxt = S_RD;
                                S_RD: begin
                                    w_rd_valid_nxt = 1'b1;
                                    w_rd_data_nxt  = m_data_out;
                                    if (r_cnt == 2'd0) w_state_nxt = S_STOP;
                                    else w_cnt_nxt = r_cnt - 2'd1;
                                end
                                S_STOP: begin
                                    w_state_nxt = RESP;
                                    w_gap_nxt   = 1'b0;
                                    w_err_nxt   = 1'b0;
                                end
                                default: ;
                            endcase
                        end
                    end else if (m_tick) begin
                        if (r_to_cnt == OW'(TIMEOUT_TICKS - 1)) begin
                            w_state_nxt   = RESP;
                            w_gap_nxt     = 1'b0;
                            w_err_nxt     = 1'b1;
                            w_timeout_nxt = 1'b1;
                        end else begin
                            w_to_nxt = r_to_cnt + OW'(1);
                        end
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Directed bench for i2c_reg_ctrl: a small I2C master model answers each command step,
// and every expectation below is a hand-computed constant.
module tb_i2c_reg_ctrl;

    localparam int CLK_HZ        = 100_000_000;
    localparam int TICK_HZ       = 4_000_000;
    localparam int TIMEOUT_TICKS = 255;

    logic       clk;
    logic       reset;
    logic       req;
    logic       rw;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
    logic [1:0] rd_len;
    logic       ready, rd_valid, resp_valid, err, timeout;
    logic [7:0] rd_data;
    logic       m_tick, m_start, m_stop, m_write, m_read, m_ack_in;
    logic [7:0] m_data_in;
    logic [7:0] m_data_out;
    logic       m_done, m_busy, m_ack_err;

    logic       d_ready, d_rd_valid, d_resp_valid, d_err, d_timeout;
    logic [7:0] d_rd_data, d_m_data_in;
    logic       d_m_tick, d_m_start, d_m_stop, d_m_write, d_m_read, d_m_ack_in;

    int total = 0;
    int bad   = 0;

    logic [7:0] wr_q[$];
    bit         start_q[$];
    bit         ack_q[$];
    logic [7:0] rd_src[$];
    logic [7:0] rd_q[$];
    int         done_cnt, done_limit, stop_cnt, resp_cnt, reg_ticks, dly;
    bit         nack_addr, stop_seen;

    i2c_reg_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .TIMEOUT_TICKS(TIMEOUT_TICKS)) dut (
        .clk(clk), .reset(reset), .req(req), .rw(rw), .dev_addr(dev_addr),
        .reg_addr(reg_addr), .wdata(wdata), .rd_len(rd_len), .ready(ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .resp_valid(resp_valid), .err(err),
        .timeout(timeout), .m_tick(m_tick), .m_start(m_start), .m_stop(m_stop),
        .m_write(m_write), .m_read(m_read), .m_ack_in(m_ack_in), .m_data_in(m_data_in),
        .m_data_out(m_data_out), .m_done(m_done), .m_busy(m_busy), .m_ack_err(m_ack_err)
    );

    // Default-parameter instance, used only to confirm the 250-clock tick period.
    i2c_reg_ctrl dut_def (
        .clk(clk), .reset(reset), .req(1'b0), .rw(1'b0), .dev_addr(7'h00),
        .reg_addr(8'h00), .wdata(8'h00), .rd_len(2'd0), .ready(d_ready),
        .rd_valid(d_rd_valid), .rd_data(d_rd_data), .resp_valid(d_resp_valid), .err(d_err),
        .timeout(d_timeout), .m_tick(d_m_tick), .m_start(d_m_start), .m_stop(d_m_stop),
        .m_write(d_m_write), .m_read(d_m_read), .m_ack_in(d_m_ack_in), .m_data_in(d_m_data_in),
        .m_data_out(8'h00), .m_done(1'b0), .m_busy(1'b0), .m_ack_err(1'b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Master model: completes any command after it has been held for three cycles.
    initial begin
        m_done = 1'b0;
        m_ack_err = 1'b0;
        m_data_out = 8'h00;
        m_busy = 1'b0;
        dly = 0;
        forever begin
            @(posedge clk);
            #1;
            m_done = 1'b0;
            m_ack_err = 1'b0;
            m_busy = m_start | m_stop | m_write | m_read;
            if (reset) begin
                dly = 0;
            end else if ((m_start | m_stop | m_write | m_read) && done_cnt < done_limit) begin
                dly++;
                if (dly == 3) begin
                    dly = 0;
                    done_cnt++;
                    m_done = 1'b1;
                    if (m_write) begin
                        wr_q.push_back(m_data_in);
                        start_q.push_back(m_start);
                        if (nack_addr && m_start) m_ack_err = 1'b1;
                    end
                    if (m_read) begin
                        ack_q.push_back(m_ack_in);
                        m_data_out = (rd_src.size() > 0) ? rd_src.pop_front() : 8'hEE;
                    end
                    if (m_stop) stop_cnt++;
                end
            end else begin
                dly = 0;
            end
        end
    end

    // Output monitor sampled on the inactive edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rd_valid) rd_q.push_back(rd_data);
            if (resp_valid) resp_cnt++;
            if (m_stop) stop_seen = 1'b1;
            if (m_tick && m_write && !m_start) reg_ticks++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clearLogs();
        wr_q.delete();
        start_q.delete();
        ack_q.delete();
        rd_src.delete();
        rd_q.delete();
        done_cnt = 0;
        done_limit = 1000;
        stop_cnt = 0;
        resp_cnt = 0;
        reg_ticks = 0;
        nack_addr = 1'b0;
        stop_seen = 1'b0;
    endtask

    task automatic applyStimulus(input logic i_rw, input logic [6:0] dv, input logic [7:0] rg,
                                 input logic [7:0] wd, input logic [1:0] ln);
        @(negedge clk);
        rw = i_rw;
        dev_addr = dv;
        reg_addr = rg;
        wdata = wd;
        rd_len = ln;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic waitResp(input string tag, input int maxCycles);
        int n = 0;
        while (!resp_valid && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_resp_seen"}, {31'd0, resp_valid}, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int n;
        req = 1'b0; rw = 1'b0; dev_addr = '0; reg_addr = '0; wdata = '0; rd_len = '0;
        clearLogs();
        reset = 1'b1;
        idle(3);
        checkOutput("rst_ready", {31'd0, ready}, 32'd1);
        checkOutput("rst_cmds", {28'd0, m_start, m_stop, m_write, m_read}, 32'd0);
        checkOutput("rst_flags", {28'd0, resp_valid, rd_valid, err, timeout}, 32'd0);
        checkOutput("rst_tick", {31'd0, m_tick}, 32'd0);
        checkOutput("rst_data", {16'd0, rd_data, m_data_in}, 32'd0);
        reset = 1'b0;
        idle(2);

        $display("[TB] register write");
        clearLogs();
        applyStimulus(1'b0, 7'h1D, 8'h2A, 8'h5A, 2'd0);
        waitResp("wr", 3000);
        checkOutput("wr_err", {30'd0, err, timeout}, 32'd0);
        @(negedge clk);
        checkOutput("wr_ready_after", {31'd0, ready}, 32'd1);
        idle(20);
        checkOutput("wr_nbytes", wr_q.size(), 32'd3);
        checkOutput("wr_byte0", {24'd0, wr_q[0]}, 32'h3A);
        checkOutput("wr_byte1", {24'd0, wr_q[1]}, 32'h2A);
        checkOutput("wr_byte2", {24'd0, wr_q[2]}, 32'h5A);
        checkOutput("wr_starts", {29'd0, start_q[0], start_q[1], start_q[2]}, 32'b100);
        checkOutput("wr_stops", stop_cnt, 32'd1);
        checkOutput("wr_resp_once", resp_cnt, 32'd1);
        checkOutput("wr_no_rd", rd_q.size(), 32'd0);

        $display("[TB] burst read of four bytes");
        clearLogs();
        rd_src = '{8'h11, 8'h22, 8'h33, 8'h44};
        applyStimulus(1'b1, 7'h1D, 8'h32, 8'h00, 2'd3);
        waitResp("rd", 6000);
        checkOutput("rd_err", {30'd0, err, timeout}, 32'd0);
        idle(20);
        checkOutput("rd_nwr", wr_q.size(), 32'd3);
        checkOutput("rd_wbytes", {8'd0, wr_q[0], wr_q[1], wr_q[2]}, 32'h003A323B);
        checkOutput("rd_starts", {29'd0, start_q[0], start_q[1], start_q[2]}, 32'b101);
        checkOutput("rd_count", rd_q.size(), 32'd4);
        checkOutput("rd_bytes", {rd_q[0], rd_q[1], rd_q[2], rd_q[3]}, 32'h11223344);
        checkOutput("rd_acks", {28'd0, ack_q[0], ack_q[1], ack_q[2], ack_q[3]}, 32'b0001);
        checkOutput("rd_stops", stop_cnt, 32'd1);
        checkOutput("rd_resp_once", resp_cnt, 32'd1);
        checkOutput("rd_data_hold", {24'd0, rd_data}, 32'h44);

        $display("[TB] address NACK");
        clearLogs();
        nack_addr = 1'b1;
        applyStimulus(1'b0, 7'h1D, 8'h2A, 8'h5A, 2'd0);
        waitResp("nack", 3000);
        checkOutput("nack_err", {30'd0, err, timeout}, 32'b10);
        @(negedge clk);
        checkOutput("nack_ready_after", {31'd0, ready}, 32'd1);
        idle(300);
        checkOutput("nack_steps", done_cnt, 32'd1);
        checkOutput("nack_no_stop", {31'd0, stop_seen}, 32'd0);
        checkOutput("nack_no_rd", rd_q.size(), 32'd0);
        checkOutput("nack_resp_once", resp_cnt, 32'd1);

        $display("[TB] timeout at register step");
        clearLogs();
        done_limit = 1;
        applyStimulus(1'b0, 7'h1D, 8'h2A, 8'h5A, 2'd0);
        waitResp("to", 10000);
        checkOutput("to_err", {30'd0, err, timeout}, 32'b11);
        checkOutput("to_ticks", reg_ticks, 32'd255);
        checkOutput("to_steps", done_cnt, 32'd1);
        idle(2);
        checkOutput("to_flags_hold", {30'd0, err, timeout}, 32'b11);

        $display("[TB] reset during second read byte");
        clearLogs();
        rd_src = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        applyStimulus(1'b1, 7'h1D, 8'h32, 8'h00, 2'd3);
        checkOutput("rst_rd_flags_cleared", {30'd0, err, timeout}, 32'd0);
        n = 0;
        while (!(rd_q.size() == 1 && m_read) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rst_rd_reached_byte2", {31'd0, (n < 3000)}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_rd_cmds", {28'd0, m_start, m_stop, m_write, m_read}, 32'd0);
        checkOutput("rst_rd_ready", {31'd0, ready}, 32'd1);
        checkOutput("rst_rd_noresp", {31'd0, resp_valid}, 32'd0);
        reset = 1'b0;
        idle(50);
        checkOutput("rst_rd_resp_none", resp_cnt, 32'd0);
        checkOutput("rst_rd_one_byte", rd_q.size(), 32'd1);

        clearLogs();
        applyStimulus(1'b0, 7'h50, 8'h01, 8'hC3, 2'd0);
        waitResp("post_rst_wr", 3000);
        checkOutput("post_rst_err", {30'd0, err, timeout}, 32'd0);
        idle(20);
        checkOutput("post_rst_bytes", {8'd0, wr_q[0], wr_q[1], wr_q[2]}, 32'h00A001C3);
        checkOutput("post_rst_stops", stop_cnt, 32'd1);

        $display("[TB] req while busy is ignored");
        clearLogs();
        applyStimulus(1'b0, 7'h22, 8'h10, 8'h77, 2'd0);
        idle(2);
        applyStimulus(1'b1, 7'h55, 8'h99, 8'h00, 2'd3);
        waitResp("busy", 3000);
        idle(300);
        checkOutput("busy_nbytes", wr_q.size(), 32'd3);
        checkOutput("busy_bytes", {8'd0, wr_q[0], wr_q[1], wr_q[2]}, 32'h00441077);
        checkOutput("busy_no_rd", rd_q.size(), 32'd0);
        checkOutput("busy_resp_once", resp_cnt, 32'd1);
        checkOutput("busy_ready", {31'd0, ready}, 32'd1);

        $display("[TB] tick periods");
        n = 0;
        while (!m_tick && n < 1000) begin @(negedge clk); n++; end
        n = 0;
        do begin @(negedge clk); n++; end while (!m_tick && n < 1000);
        checkOutput("tick_period_25", n, 32'd25);
        n = 0;
        while (!d_m_tick && n < 1000) begin @(negedge clk); n++; end
        n = 0;
        do begin @(negedge clk); n++; end while (!d_m_tick && n < 1000);
        checkOutput("tick_period_250", n, 32'd250);
        checkOutput("def_idle", {29'd0, d_ready, d_resp_valid, d_err}, 32'b100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
